// File: rtl/int2float16_stream_ctrl.sv
// Job sequencer feeding buffer words through the int->fp16 converter into a credit-managed
// output FIFO, streamed out with valid/ready.
module int2float16_stream_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int MEM_LAT    = 1,
  parameter int CNV_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              cast_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       num_words_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [15:0]       rd_data_i,
  output logic              cnv_cast_o,
  output logic [15:0]       cnv_data_o,
  input  logic [15:0]       cnv_result_i,
  output logic              out_valid_o,
  output logic [15:0]       out_data_o,
  input  logic              out_ready_i
);

  localparam int TAG_LEN = MEM_LAT + CNV_LAT;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W   = $clog2(TAG_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [15:0]        num_words;
  logic [15:0]        issued_count;
  logic [ADDR_W-1:0]  base_addr;
  logic [TAG_LEN-1:0] tags;
  logic [INF_W-1:0]   inflight;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               credit_ok;
  logic               push;
  logic               pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < TAG_LEN; i++) begin
      inflight = inflight + INF_W'(tags[i]);
    end
  end

  // A read is only issued when a FIFO slot is already reserved for its result.
  assign credit_ok   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign rd_en_o     = (state == RUN) && credit_ok;
  assign rd_addr_o   = base_addr + ADDR_W'(issued_count);
  assign cnv_data_o  = rd_data_i;
  assign push        = tags[TAG_LEN-1];
  assign out_valid_o = (fifo_count != '0);
  assign out_data_o  = fifo_mem[rd_ptr];
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      cnv_cast_o   <= 1'b0;
      base_addr    <= '0;
      num_words    <= '0;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cnv_cast_o   <= cast_i;
            base_addr    <= base_addr_i;
            num_words    <= num_words_i;
            issued_count <= '0;
            busy_o       <= 1'b1;
            if (num_words_i != 16'd0) begin
              state <= RUN;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en_o) begin
            issued_count <= issued_count + 16'd1;
            if (issued_count + 16'd1 == num_words) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tags == '0 && fifo_count == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done_o     <= 1'b0;
          busy_o     <= 1'b0;
          cnv_cast_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline mirrors the memory + converter latency so results are captured on time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tags <= '0;
    end else begin
      tags[0] <= rd_en_o;
      for (int i = 1; i < TAG_LEN; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= cnv_result_i;
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && fifo_count == CNT_W'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_int2float16_stream_ctrl.sv
// Directed bench for int2float16_stream_ctrl with behavioural buffer and converter models.
module tb_int2float16_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic        cast_i;
  logic [11:0] base_addr_i;
  logic [15:0] num_words_i;
  logic        busy_o;
  logic        done_o;
  logic        rd_en_o;
  logic [11:0] rd_addr_o;
  logic [15:0] rd_data_i = '0;
  logic        cnv_cast_o;
  logic [15:0] cnv_data_o;
  logic [15:0] cnv_result_i;
  logic        out_valid_o;
  logic [15:0] out_data_o;
  logic        out_ready_i;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] mem [4096];
  logic [15:0] cnv_s1 = '0;
  logic [15:0] cnv_s2 = '0;

  logic [11:0] addr_q [$];
  logic [15:0] out_q [$];
  int rd_count, pop_count, done_count, cast_high, max_out, hold_err;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  int2float16_stream_ctrl #(
    .ADDR_W(12), .MEM_LAT(1), .CNV_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .cast_i(cast_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i), .busy_o(busy_o),
    .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .cnv_cast_o(cnv_cast_o), .cnv_data_o(cnv_data_o), .cnv_result_i(cnv_result_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  // Signed int16 to fp16 reference conversion, exact for the small magnitudes used here.
  function automatic logic [15:0] to_fp16(input logic [15:0] v);
    logic [15:0] mag;
    logic [15:0] r;
    int p;
    mag = v[15] ? (~v + 16'd1) : v;
    if (mag == 16'd0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    r[15]    = v[15];
    r[14:10] = 5'(p + 15);
    if (p >= 10) r[9:0] = 10'(mag >> (p - 10));
    else         r[9:0] = 10'(mag << (10 - p));
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en_o === 1'b1) rd_data_i <= mem[rd_addr_o];
    cnv_s1 <= (cnv_cast_o === 1'b1) ? to_fp16(cnv_data_o) : cnv_data_o;
    cnv_s2 <= cnv_s1;
  end
  assign cnv_result_i = cnv_s2;

  always @(negedge clk) begin
    if (rd_en_o === 1'b1) begin
      addr_q.push_back(rd_addr_o);
      rd_count++;
    end
    if (prev_stall && (out_valid_o !== 1'b1 || out_data_o !== prev_data)) hold_err++;
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      out_q.push_back(out_data_o);
      pop_count++;
    end
    if (done_o === 1'b1) done_count++;
    if (cnv_cast_o === 1'b1) cast_high++;
    if (rd_count - pop_count > max_out) max_out = rd_count - pop_count;
    prev_stall = (out_valid_o === 1'b1) && (out_ready_i === 1'b0);
    prev_data  = out_data_o;
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    out_q.delete();
    rd_count = 0; pop_count = 0; done_count = 0;
    cast_high = 0; max_out = 0; hold_err = 0;
  endtask

  // Pulses start for one cycle, then scrambles the job inputs to prove they were latched.
  task automatic applyStimulus(input logic cast_v, input logic [11:0] base_v,
                               input logic [15:0] num_v);
    start_i = 1'b1; cast_i = cast_v; base_addr_i = base_v; num_words_i = num_v;
    step_cycle();
    start_i = 1'b0; cast_i = ~cast_v; base_addr_i = 12'hABC; num_words_i = 16'h7777;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_count == 0 && n < 500) begin
      step_cycle();
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n < 500), 32'd1);
    step_cycle();
    step_cycle();
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; cast_i = 1'b0;
    base_addr_i = '0; num_words_i = '0; out_ready_i = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A00;
    mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h0005; mem[12'h012] = 16'h0080;
    mem[12'h020] = 16'h3C00; mem[12'h021] = 16'hC000;
    clear_logs();
    repeat (3) step_cycle();

    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_cast", 32'(cnv_cast_o), 32'd0);
    checkOutput("rst_addr", 32'(rd_addr_o), 32'd0);
    checkOutput("rst_data", 32'(out_data_o), 32'd0);
    reset_n = 1'b1;
    step_cycle();

    // T1: int cast mode
    clear_logs();
    applyStimulus(1'b1, 12'h010, 16'd3);
    checkOutput("t1_busy", 32'(busy_o), 32'd1);
    checkOutput("t1_cast_o", 32'(cnv_cast_o), 32'd1);
    wait_done("t1");
    checkOutput("t1_count", 32'(out_q.size()), 32'd3);
    checkOutput("t1_w0", 32'(out_q[0]), 32'h0000BC00);
    checkOutput("t1_w1", 32'(out_q[1]), 32'h00004500);
    checkOutput("t1_w2", 32'(out_q[2]), 32'h00005800);
    checkOutput("t1_done_cycles", 32'(done_count), 32'd1);
    checkOutput("t1_addr2", 32'(addr_q[2]), 32'h012);
    checkOutput("t1_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("t1_idle_cast", 32'(cnv_cast_o), 32'd0);

    // T2: passthrough
    clear_logs();
    applyStimulus(1'b0, 12'h020, 16'd2);
    wait_done("t2");
    checkOutput("t2_count", 32'(out_q.size()), 32'd2);
    checkOutput("t2_w0", 32'(out_q[0]), 32'h00003C00);
    checkOutput("t2_w1", 32'(out_q[1]), 32'h0000C000);
    checkOutput("t2_cast_cycles", 32'(cast_high), 32'd0);

    // T3: backpressure during cycles 5-20 of the job
    clear_logs();
    applyStimulus(1'b0, 12'h100, 16'd16);
    repeat (4) step_cycle();
    out_ready_i = 1'b0;
    repeat (16) step_cycle();
    checkOutput("t3_stalled", 32'(rd_count < 16), 32'd1);
    checkOutput("t3_outstanding", 32'(rd_count - pop_count), 32'd4);
    out_ready_i = 1'b1;
    wait_done("t3");
    checkOutput("t3_count", 32'(out_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t3_w%0d", i), 32'(out_q[i]), 32'(mem[12'h100 + 12'(i)]));
    end
    checkOutput("t3_max_outstanding", 32'(max_out), 32'd4);
    checkOutput("t3_hold", 32'(hold_err), 32'd0);

    // T4: empty job, then address wrap
    clear_logs();
    applyStimulus(1'b0, 12'h055, 16'd0);
    checkOutput("t4_done_next", 32'(done_o), 32'd1);
    checkOutput("t4_rd_en", 32'(rd_en_o), 32'd0);
    step_cycle();
    checkOutput("t4_done_low", 32'(done_o), 32'd0);
    checkOutput("t4_no_reads", 32'(rd_count), 32'd0);
    clear_logs();
    applyStimulus(1'b0, 12'hFFE, 16'd4);
    wait_done("t4w");
    checkOutput("t4_naddr", 32'(addr_q.size()), 32'd4);
    checkOutput("t4_a0", 32'(addr_q[0]), 32'hFFE);
    checkOutput("t4_a1", 32'(addr_q[1]), 32'hFFF);
    checkOutput("t4_a2", 32'(addr_q[2]), 32'h000);
    checkOutput("t4_a3", 32'(addr_q[3]), 32'h001);
    checkOutput("t4_w2", 32'(out_q[2]), 32'(mem[12'h000]));
    checkOutput("t4_w3", 32'(out_q[3]), 32'(mem[12'h001]));

    // T5: start while running is ignored
    clear_logs();
    applyStimulus(1'b0, 12'h200, 16'd6);
    step_cycle();
    step_cycle();
    start_i = 1'b1; base_addr_i = 12'h250; num_words_i = 16'd2; cast_i = 1'b1;
    step_cycle();
    start_i = 1'b0;
    wait_done("t5");
    checkOutput("t5_count", 32'(out_q.size()), 32'd6);
    checkOutput("t5_w0", 32'(out_q[0]), 32'(mem[12'h200]));
    checkOutput("t5_w5", 32'(out_q[5]), 32'(mem[12'h205]));
    checkOutput("t5_a5", 32'(addr_q[5]), 32'h205);
    checkOutput("t5_cast_cycles", 32'(cast_high), 32'd0);

    // T6: reset mid-job
    clear_logs();
    applyStimulus(1'b1, 12'h300, 16'd10);
    begin
      int n = 0;
      while (pop_count < 5 && n < 200) begin
        step_cycle();
        n++;
      end
      checkOutput("t6_timeout", 32'(n < 200), 32'd1);
    end
    reset_n = 1'b0;
    step_cycle();
    checkOutput("t6_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("t6_valid", 32'(out_valid_o), 32'd0);
    checkOutput("t6_cast", 32'(cnv_cast_o), 32'd0);
    checkOutput("t6_addr", 32'(rd_addr_o), 32'd0);
    checkOutput("t6_data", 32'(out_data_o), 32'd0);
    reset_n = 1'b1;
    step_cycle();
    clear_logs();
    applyStimulus(1'b0, 12'h400, 16'd3);
    wait_done("t6n");
    checkOutput("t6_count", 32'(out_q.size()), 32'd3);
    checkOutput("t6_reads", 32'(rd_count), 32'd3);
    checkOutput("t6_w0", 32'(out_q[0]), 32'(mem[12'h400]));
    checkOutput("t6_w2", 32'(out_q[2]), 32'(mem[12'h402]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
